// File: rtl/pc_gen_if.sv
// Redirect request / PC status bundle between the fetch control logic and pc_gen.
// The master drives the redirect requests; the slave (pc_gen) returns PC, EPC and RAS state.
interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             branch;
  logic [XLEN-1:0]  branch_target;
  logic             jump;
  logic [XLEN-1:0]  jump_target;
  logic             call;
  logic             ret;
  logic             trap;
  logic             mret;
  logic [XLEN-1:0]  pc_out;
  logic [XLEN-1:0]  epc;
  logic             misaligned;
  logic [CNT_W-1:0] ras_count;

  modport master (
    output stall, branch, branch_target, jump, jump_target, call, ret, trap, mret,
    input  pc_out, epc, misaligned, ras_count
  );

  modport slave (
    input  stall, branch, branch_target, jump, jump_target, call, ret, trap, mret,
    output pc_out, epc, misaligned, ras_count
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised trap/mret/stall/jump/branch/sequential
// redirect, exception PC register and a circular return-address stack.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  pc_gen_if.slave  bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic             mis_q, mis_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];

  logic [XLEN-1:0]  seq_pc;
  logic [PTR_W-1:0] ptr_top;
  logic [XLEN-1:0]  target;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             do_pop;

  assign seq_pc  = pc_q + XLEN'(4);
  assign ptr_top = ptr_q - PTR_W'(1);
  assign do_pop  = bus.ret && (cnt_q != '0);

  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    mis_d  = 1'b0;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    target = bus.branch_target;

    if (bus.jump)
      target = do_pop ? ras_q[ptr_top] : bus.jump_target;

    if (bus.trap) begin
      epc_d = pc_q;
      pc_d  = TRAP_VECTOR;
    end else if (bus.mret) begin
      pc_d = epc_q;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.jump || bus.branch) begin
      if (target[1:0] != 2'b00) begin
        epc_d = pc_q;
        pc_d  = TRAP_VECTOR;
        mis_d = 1'b1;
      end else begin
        pc_d = target;
        if (bus.jump) begin
          // call+ret on a non-empty stack replaces the top in place
          if (do_pop && bus.call) begin
            wr_en  = 1'b1;
            wr_idx = ptr_top;
          end else if (do_pop) begin
            ptr_d = ptr_top;
            cnt_d = cnt_q - CNT_W'(1);
          end else if (bus.call) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH))
              cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    end else begin
      pc_d = seq_pc;
    end
  end

  // The return address pushed is always the calling instruction's PC + 4.
  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      assign ras_d[gi] = (wr_en && (wr_idx == PTR_W'(gi))) ? seq_pc : ras_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= ras_d[i];
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.epc        = epc_q;
  assign bus.misaligned = mis_q;
  assign bus.ras_count  = cnt_q;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V fetch stage, replacing the fixed 32-bit PC register. Resolves trap, trap-return, jump, branch, stall and sequential redirects by fixed priority. Holds the exception PC and a small circular return-address stack (RAS) that predicts `ret` targets. Traps on misaligned redirect targets.

## Interface
- `XLEN`, 32: PC/address width.
- `RESET_VECTOR`, 0: `pc_out` value after reset.
- `TRAP_VECTOR`, 'h100: target on trap or misaligned redirect.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC and RAS.
- `branch` in 1, `branch_target` in XLEN: taken branch and its target.
- `jump` in 1, `jump_target` in XLEN: jump and its target.
- `call` in 1: qualifies `jump`; push return address.
- `ret` in 1: qualifies `jump`; pop RAS for target.
- `trap` in 1: take exception.
- `mret` in 1: return from exception to `epc`.
- `pc_out` out XLEN: current PC.
- `epc` out XLEN: saved exception PC.
- `misaligned` out 1: one-cycle pulse, misaligned-redirect trap taken.
- `ras_count` out $clog2(RAS_DEPTH)+1: valid RAS entries.

## Operation
- Reset (`reset_n`=0): `pc_out`=RESET_VECTOR, `epc`=0, `misaligned`=0, `ras_count`=0, RAS pointer=0, RAS entries=0.
- Per edge, first matching rule wins:
  1. `trap`: `epc`<=`pc_out`, `pc_out`<=TRAP_VECTOR. Applies even when `stall`=1.
  2. `mret`: `pc_out`<=`epc`. Applies even when `stall`=1.
  3. `stall`: hold `pc_out`, RAS and `epc`. Ignore `jump`, `branch`, `call`, `ret`.
  4. `jump`: select the target (RAS rules below).
  5. `branch`: target=`branch_target`.
  6. Otherwise: `pc_out`<=`pc_out`+4, modulo 2^XLEN (all-ones-minus-3 wraps to 0).
- Misalignment check (rules 4/5 only):
  - Target with bits [1:0]≠0: take a trap instead (`epc`<=`pc_out`, `pc_out`<=TRAP_VECTOR, `misaligned`=1 for that cycle).
  - RAS is not modified by the faulting jump.
- `misaligned` is registered. It is 0 on every edge that does not take a misaligned trap.
- `call`/`ret` are ignored unless `jump`=1.
- RAS rules for a non-stalled, aligned jump:
  - `ret` with `ras_count`>0: target=top entry; pop (pointer−1, count−1).
  - `ret` with `ras_count`=0: target=`jump_target`; no pop.
  - Target check is applied to the final selected target, including a popped value.
  - `call`: push `pc_out`+4 (mod 2^XLEN).
  - Push when full: overwrite the oldest entry (circular pointer); `ras_count` saturates at RAS_DEPTH.
  - `call`+`ret` together: pop-then-push. Target=top, top<=`pc_out`+4, count unchanged. If the RAS was empty: target=`jump_target`, count becomes 1.
- `trap` and `mret` never touch the RAS.
- `trap`+`mret` together: trap wins; `epc`<=`pc_out`.

## Timing
- All outputs are registered. Inputs are sampled at a rising `clk` edge and take effect in `pc_out` after that same edge (1-cycle latency). No combinational input→output path.
- Reset assertion is immediate and asynchronous. The first rising edge with `reset_n`=1 performs a normal update from RESET_VECTOR.
- Reset mid-operation discards all RAS contents and `epc`.
- Redirect inputs are level-sensitive single-cycle requests. Holding one high for N cycles applies it N times (e.g. `call` held 2 cycles pushes twice).

## Test plan
- Reset + sequential:
  - Stimulus: RESET_VECTOR='h1000; release `reset_n`; 3 idle edges.
  - Required: `pc_out`='h1000 → 'h1004 → 'h1008 → 'h100C.
  - Then `pc_out`='hFFFF_FFFC + idle edge → 0.
- Priority:
  - At `pc_out`='h20, assert `jump`(target 'h80) + `branch`(target 'h40) → 'h80.
  - With `stall`=1 as well → `pc_out` holds 'h20.
  - Add `trap` → `pc_out`='h100, `epc`='h20.
  - Then `mret` → `pc_out`='h20.
- Call/return:
  - `call` at 'h10 (target 'h200) → `pc_out`='h200, `ras_count`=1.
  - `ret` with `jump_target`='h999C → `pc_out`='h14, `ras_count`=0.
  - Another `ret` (target 'h300) → `pc_out`='h300, `ras_count`=0.
- RAS overflow, RAS_DEPTH=4:
  - 5 calls from 'h0,'h100,'h200,'h300,'h400.
  - Required: `ras_count`=4.
  - 4 rets → targets 'h404,'h304,'h204,'h104; `ras_count`=0.
- Misaligned:
  - `branch` to 'h42 at `pc_out`='h30 → `pc_out`='h100, `epc`='h30, `misaligned`=1 for one cycle.
  - `jump`+`call` to 'h43 → trap; `ras_count` unchanged.
- Async reset mid-stream:
  - Drop `reset_n` between edges with `ras_count`=2.
  - Required: `pc_out`=RESET_VECTOR and `ras_count`=0 immediately, before the next edge.
